// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational 8-bit ALU between two requesters.
// Operands and the result are registered; at most one transaction is in flight.
//
// state | meaning
// IDLE  | no transaction; grant the favoured valid requester
// EXEC  | operand registers drive the ALU; capture alu_out
// RESP  | hold the result to the granted requester until it is taken
module alu_arbiter #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [2*SEL_W-1:0] req_sel,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [SEL_W-1:0]   alu_select,
  input  logic [WIDTH-1:0]   alu_out,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count0,
  output logic [CNT_W-1:0]   op_count1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state;
  logic               fav;
  logic               gnt;
  logic               pick;
  logic               any_valid;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [SEL_W-1:0]   opsel;
  logic [WIDTH-1:0]   res;
  logic [WIDTH-1:0]   pick_a;
  logic [WIDTH-1:0]   pick_b;
  logic [SEL_W-1:0]   pick_sel;

  always_comb begin
    any_valid = |req_valid;
    pick      = req_valid[fav] ? fav : ~fav;
    pick_a    = pick ? req_a[2*WIDTH-1:WIDTH]   : req_a[WIDTH-1:0];
    pick_b    = pick ? req_b[2*WIDTH-1:WIDTH]   : req_b[WIDTH-1:0];
    pick_sel  = pick ? req_sel[2*SEL_W-1:SEL_W] : req_sel[SEL_W-1:0];
    req_ready = 2'b00;
    // gated by rst_n so every output reads zero while reset is held
    if (rst_n && (state == IDLE) && any_valid) begin
      req_ready[pick] = 1'b1;
    end
  end

  assign alu_a      = opa;
  assign alu_b      = opb;
  assign alu_select = opsel;
  assign rsp_data   = res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fav       <= 1'b0;
      gnt       <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      opsel     <= '0;
      res       <= '0;
      rsp_valid <= 2'b00;
      busy      <= 1'b0;
      op_count0 <= '0;
      op_count1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            opa   <= pick_a;
            opb   <= pick_b;
            opsel <= pick_sel;
            gnt   <= pick;
            fav   <= ~pick;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          res       <= alu_out;
          rsp_valid <= gnt ? 2'b10 : 2'b01;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready[gnt]) begin
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
            state     <= IDLE;
            if (gnt) op_count1 <= op_count1 + 1'b1;
            else     op_count0 <= op_count0 + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
